// File: rtl/id_fetch_sequencer.sv
// IF/ID controller: accepts a PC, fetches one instruction over a valid/ready imem port,
// decodes its ImmSel class and holds {pc, inst, imm_sel} for EX until accepted.
module id_fetch_sequencer #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_valid,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_ready,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  input  logic              imem_rsp_err,
  input  logic              flush,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [31:0]       id_inst,
  output logic [2:0]        id_imm_sel,
  output logic              id_illegal,
  output logic              id_fetch_err
);

  localparam logic [2:0]  IMM_I    = 3'd0;
  localparam logic [2:0]  IMM_S    = 3'd1;
  localparam logic [2:0]  IMM_B    = 3'd2;
  localparam logic [2:0]  IMM_U    = 3'd3;
  localparam logic [2:0]  IMM_J    = 3'd4;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       inst_q, inst_d;
  logic [2:0]        imm_sel_q, imm_sel_d;
  logic              illegal_q, illegal_d;
  logic              ferr_q, ferr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              drain_q, drain_d;

  logic [2:0] dec_sel;
  logic       dec_ill;
  logic       timeout_hit;
  logic [7:0] cnt_inc;

  always_comb begin
    dec_sel = IMM_I;
    dec_ill = 1'b0;
    case (imem_rsp_data[6:0])
      7'b0110111, 7'b0010111: dec_sel = IMM_U;
      7'b1101111:             dec_sel = IMM_J;
      7'b1100011:             dec_sel = IMM_B;
      7'b0100011:             dec_sel = IMM_S;
      7'b1100111, 7'b0000011, 7'b0010011,
      7'b1110011, 7'b0110011: dec_sel = IMM_I;
      default:                dec_ill = 1'b1;
    endcase
  end

  assign timeout_hit = (cnt_q == CNT_LAST);
  assign cnt_inc     = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    inst_d         = inst_q;
    imm_sel_d      = imm_sel_q;
    illegal_d      = illegal_q;
    ferr_d         = ferr_q;
    cnt_d          = cnt_q;
    drain_d        = drain_q;
    pc_ready       = 1'b0;
    imem_req_valid = 1'b0;
    id_valid       = 1'b0;
    case (state_q)
      S_IDLE: begin
        pc_ready = !drain_q && !rst;
        // The drain window keeps running the response timer of the flushed fetch.
        if (drain_q) begin
          cnt_d = cnt_inc;
          if (imem_rsp_valid || timeout_hit) drain_d = 1'b0;
        end else if (pc_valid) begin
          pc_d    = pc_in;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        imem_req_valid = !flush;
        if (flush) begin
          state_d = S_IDLE;
        end else if (imem_req_ready) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        if (flush) begin
          state_d = S_IDLE;
          // No drain needed if the response lands now or the fetch times out now.
          drain_d = !imem_rsp_valid && !timeout_hit;
        end else if (imem_rsp_valid) begin
          state_d   = S_HOLD;
          inst_d    = imem_rsp_err ? NOP : imem_rsp_data;
          imm_sel_d = imem_rsp_err ? IMM_I : dec_sel;
          illegal_d = !imem_rsp_err && dec_ill;
          ferr_d    = imem_rsp_err;
        end else if (timeout_hit) begin
          state_d   = S_HOLD;
          inst_d    = NOP;
          imm_sel_d = IMM_I;
          illegal_d = 1'b0;
          ferr_d    = 1'b1;
        end
      end
      S_HOLD: begin
        id_valid = 1'b1;
        if (flush || id_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      inst_q    <= '0;
      imm_sel_q <= IMM_I;
      illegal_q <= 1'b0;
      ferr_q    <= 1'b0;
      cnt_q     <= '0;
      drain_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      imm_sel_q <= imm_sel_d;
      illegal_q <= illegal_d;
      ferr_q    <= ferr_d;
      cnt_q     <= cnt_d;
      drain_q   <= drain_d;
    end
  end

  assign imem_req_addr = pc_q;
  assign id_pc         = pc_q;
  assign id_inst       = inst_q;
  assign id_imm_sel    = imm_sel_q;
  assign id_illegal    = illegal_q;
  assign id_fetch_err  = ferr_q;

endmodule

// File: tb/tb_id_fetch_sequencer.sv
// Bench for id_fetch_sequencer: directed scenarios plus a randomized run against a
// transaction-level reference model (deadline-based timeout, scheduled imem responses).
module tb_id_fetch_sequencer;

  localparam int          TMO   = 4;
  localparam logic [2:0]  SEL_I = 3'd0;
  localparam logic [2:0]  SEL_S = 3'd1;
  localparam logic [2:0]  SEL_B = 3'd2;
  localparam logic [2:0]  SEL_U = 3'd3;
  localparam logic [2:0]  SEL_J = 3'd4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_valid, imem_req_ready, imem_rsp_valid, imem_rsp_err, flush, id_ready;
  logic [31:0] pc_in, imem_rsp_data;
  logic        pc_ready, imem_req_valid, id_valid, id_illegal, id_fetch_err;
  logic [31:0] imem_req_addr, id_pc, id_inst;
  logic [2:0]  id_imm_sel;

  int n_cmp = 0;
  int n_bad = 0;

  id_fetch_sequencer #(.ADDR_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .pc_valid(pc_valid), .pc_in(pc_in), .pc_ready(pc_ready),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .imem_rsp_err(imem_rsp_err), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst),
    .id_imm_sel(id_imm_sel), .id_illegal(id_illegal), .id_fetch_err(id_fetch_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    pc_valid = 1'b0; pc_in = '0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    imem_rsp_data = '0; imem_rsp_err = 1'b0; flush = 1'b0; id_ready = 1'b0;
  endtask

  // Stimulus only: zero-wait fetch from IDLE, leaves the instruction held (id_ready low).
  task automatic issue(input logic [31:0] pc, input logic [31:0] inst, input logic err);
    pc_valid = 1'b1; pc_in = pc; imem_req_ready = 1'b1;
    tick;
    pc_valid = 1'b0;
    tick;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = inst; imem_rsp_err = err;
    tick;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; imem_rsp_err = 1'b0;
  endtask

  function automatic logic [3:0] ref_decode(input logic [31:0] inst);
    case (inst[6:0])
      7'h37, 7'h17:                      return {1'b0, SEL_U};
      7'h6F:                             return {1'b0, SEL_J};
      7'h63:                             return {1'b0, SEL_B};
      7'h23:                             return {1'b0, SEL_S};
      7'h67, 7'h03, 7'h13, 7'h73, 7'h33: return {1'b0, SEL_I};
      default:                           return {1'b1, SEL_I};
    endcase
  endfunction

  task automatic test_reset;
    logic [104:0] all_out;
    idle_inputs();
    rst = 1'b1;
    tick; tick;
    all_out = {pc_ready, imem_req_valid, id_valid, id_illegal, id_fetch_err, id_imm_sel,
               imem_req_addr, id_pc, id_inst};
    n_cmp++;
    if (all_out !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (pc_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_release_pc_ready: got %b want 1", pc_ready);
    end
  endtask

  task automatic test_auipc;
    pc_valid = 1'b1; pc_in = 32'h8000_0000; imem_req_ready = 1'b1;
    tick;
    pc_valid = 1'b0;
    n_cmp++;
    if ({id_valid, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 32'h8000_0000}) begin
      n_bad++; $display("FAIL auipc_req: got %b/%b/%h want 0/1/80000000",
                        id_valid, imem_req_valid, imem_req_addr);
    end
    tick;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0297;
    #1;
    n_cmp++;
    if (id_valid !== 1'b0) begin
      n_bad++; $display("FAIL auipc_early_valid: got %b want 0", id_valid);
    end
    tick;
    imem_rsp_valid = 1'b0;
    n_cmp++;
    if ({id_valid, id_imm_sel, id_pc, id_inst, id_illegal, id_fetch_err} !==
        {1'b1, SEL_U, 32'h8000_0000, 32'h0000_0297, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL auipc_issue: got v=%b sel=%0d pc=%h inst=%h ill=%b err=%b want v=1 sel=%0d pc=80000000 inst=00000297 ill=0 err=0",
                        id_valid, id_imm_sel, id_pc, id_inst, id_illegal, id_fetch_err, SEL_U);
    end
    id_ready = 1'b1;
    tick;
    id_ready = 1'b0;
    n_cmp++;
    if ({id_valid, pc_ready} !== 2'b01) begin
      n_bad++; $display("FAIL auipc_accept: got valid/pc_ready %b%b want 01", id_valid, pc_ready);
    end
  endtask

  task automatic test_hold_stall;
    issue(32'h8000_0004, 32'hFE00_0EE3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({id_valid, id_inst, id_imm_sel} !== {1'b1, 32'hFE00_0EE3, SEL_B}) begin
        n_bad++; $display("FAIL hold_stable[%0d]: got %b/%h/%0d want 1/fe000ee3/%0d",
                          i, id_valid, id_inst, id_imm_sel, SEL_B);
      end
      tick;
    end
    id_ready = 1'b1;
    tick;
    id_ready = 1'b0;
    n_cmp++;
    if ({id_valid, pc_ready} !== 2'b01) begin
      n_bad++; $display("FAIL hold_release: got %b%b want 01", id_valid, pc_ready);
    end
  endtask

  task automatic test_decode;
    logic [31:0] insts[10];
    logic [3:0]  exp[10];
    insts = '{32'h0000_006F, 32'h0000_2023, 32'h0000_2003, 32'h0000_007F, 32'h0000_00B3,
              32'h0000_0513, 32'h0000_02B7, 32'h0000_8067, 32'h0000_0073, 32'h0000_0010};
    exp   = '{{1'b0, SEL_J}, {1'b0, SEL_S}, {1'b0, SEL_I}, {1'b1, SEL_I}, {1'b0, SEL_I},
              {1'b0, SEL_I}, {1'b0, SEL_U}, {1'b0, SEL_I}, {1'b0, SEL_I}, {1'b1, SEL_I}};
    for (int i = 0; i < 10; i++) begin
      issue(32'h100 + 32'(4 * i), insts[i], 1'b0);
      n_cmp++;
      if ({id_valid, id_illegal, id_imm_sel, id_inst} !== {1'b1, exp[i], insts[i]}) begin
        n_bad++; $display("FAIL decode[%0d]: got v=%b ill=%b sel=%0d inst=%h want v=1 ill=%b sel=%0d inst=%h",
                          i, id_valid, id_illegal, id_imm_sel, id_inst, exp[i][3], exp[i][2:0], insts[i]);
      end
      id_ready = 1'b1;
      tick;
      id_ready = 1'b0;
    end
  endtask

  task automatic test_flush;
    // Flush in REQ withdraws the request in the same cycle.
    pc_valid = 1'b1; pc_in = 32'h200;
    tick;
    pc_valid = 1'b0;
    #1;
    n_cmp++;
    if (imem_req_valid !== 1'b1) begin
      n_bad++; $display("FAIL flush_req_pre: got %b want 1", imem_req_valid);
    end
    flush = 1'b1;
    #1;
    n_cmp++;
    if (imem_req_valid !== 1'b0) begin
      n_bad++; $display("FAIL flush_req_withdraw: got %b want 0", imem_req_valid);
    end
    tick;
    flush = 1'b0;
    n_cmp++;
    if ({pc_ready, imem_req_valid} !== 2'b10) begin
      n_bad++; $display("FAIL flush_req_idle: got %b%b want 10", pc_ready, imem_req_valid);
    end
    // Flush in HOLD.
    issue(32'h204, NOP, 1'b0);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    n_cmp++;
    if ({id_valid, pc_ready} !== 2'b01) begin
      n_bad++; $display("FAIL flush_hold: got %b%b want 01", id_valid, pc_ready);
    end
    // Flush in WAIT, stale response two cycles later.
    pc_valid = 1'b1; pc_in = 32'h300; imem_req_ready = 1'b1;
    tick;
    pc_valid = 1'b0;
    tick;
    imem_req_ready = 1'b0; flush = 1'b1;
    tick;
    flush = 1'b0; pc_valid = 1'b1; pc_in = 32'h400;
    #1;
    n_cmp++;
    if (pc_ready !== 1'b0) begin
      n_bad++; $display("FAIL drain_pc_ready0: got %b want 0", pc_ready);
    end
    tick;
    n_cmp++;
    if ({pc_ready, imem_req_valid} !== 2'b00) begin
      n_bad++; $display("FAIL drain_blocked: got %b%b want 00", pc_ready, imem_req_valid);
    end
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_006F;
    tick;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    n_cmp++;
    if ({id_valid, pc_ready, imem_req_valid} !== 3'b010) begin
      n_bad++; $display("FAIL drain_drop: got %b%b%b want 010", id_valid, pc_ready, imem_req_valid);
    end
    issue(32'h400, 32'h0050_0093, 1'b0);
    n_cmp++;
    if ({id_valid, id_pc, id_inst, id_imm_sel, id_fetch_err} !==
        {1'b1, 32'h400, 32'h0050_0093, SEL_I, 1'b0}) begin
      n_bad++; $display("FAIL drain_next_fetch: got v=%b pc=%h inst=%h sel=%0d err=%b want v=1 pc=400 inst=00500093 sel=0 err=0",
                        id_valid, id_pc, id_inst, id_imm_sel, id_fetch_err);
    end
    id_ready = 1'b1;
    tick;
    id_ready = 1'b0;
  endtask

  task automatic test_drain_timeout;
    pc_valid = 1'b1; pc_in = 32'h340; imem_req_ready = 1'b1;
    tick;
    pc_valid = 1'b0;
    tick;
    imem_req_ready = 1'b0; flush = 1'b1;
    tick;
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (pc_ready !== (i == 3)) begin
        n_bad++; $display("FAIL drain_timeout[%0d]: got pc_ready %b want %b", i, pc_ready, (i == 3));
      end
      if (i < 3) tick;
    end
  endtask

  task automatic test_timeout;
    pc_valid = 1'b1; pc_in = 32'h500; imem_req_ready = 1'b1;
    tick;
    pc_valid = 1'b0;
    tick;
    imem_req_ready = 1'b0;
    for (int i = 0; i < TMO - 1; i++) begin
      tick;
      n_cmp++;
      if (id_valid !== 1'b0) begin
        n_bad++; $display("FAIL timeout_early[%0d]: got %b want 0", i, id_valid);
      end
    end
    tick;
    n_cmp++;
    if ({id_valid, id_fetch_err, id_inst, id_imm_sel, id_illegal, id_pc} !==
        {1'b1, 1'b1, NOP, SEL_I, 1'b0, 32'h500}) begin
      n_bad++; $display("FAIL timeout_hold: got v=%b err=%b inst=%h sel=%0d ill=%b pc=%h want v=1 err=1 inst=00000013 sel=0 ill=0 pc=500",
                        id_valid, id_fetch_err, id_inst, id_imm_sel, id_illegal, id_pc);
    end
    id_ready = 1'b1;
    tick;
    id_ready = 1'b0;
    issue(32'h504, 32'h0000_007F, 1'b1);
    n_cmp++;
    if ({id_valid, id_fetch_err, id_inst, id_imm_sel, id_illegal} !==
        {1'b1, 1'b1, NOP, SEL_I, 1'b0}) begin
      n_bad++; $display("FAIL rsp_err_hold: got v=%b err=%b inst=%h sel=%0d ill=%b want v=1 err=1 inst=00000013 sel=0 ill=0",
                        id_valid, id_fetch_err, id_inst, id_imm_sel, id_illegal);
    end
    id_ready = 1'b1;
    tick;
    id_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [104:0] all_out;
    pc_valid = 1'b1; pc_in = 32'h600; imem_req_ready = 1'b1;
    tick;
    pc_valid = 1'b0;
    tick;
    imem_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    all_out = {pc_ready, imem_req_valid, id_valid, id_illegal, id_fetch_err, id_imm_sel,
               imem_req_addr, id_pc, id_inst};
    n_cmp++;
    if (all_out !== '0) begin
      n_bad++; $display("FAIL reset_in_wait: got %h want 0", all_out);
    end
    tick;
    rst = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_006F;
    tick;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    n_cmp++;
    if ({id_valid, pc_ready} !== 2'b01) begin
      n_bad++; $display("FAIL orphan_rsp: got %b%b want 01", id_valid, pc_ready);
    end
    issue(32'h604, 32'h0000_006F, 1'b0);
    rst = 1'b1;
    #1;
    all_out = {pc_ready, imem_req_valid, id_valid, id_illegal, id_fetch_err, id_imm_sel,
               imem_req_addr, id_pc, id_inst};
    n_cmp++;
    if (all_out !== '0) begin
      n_bad++; $display("FAIL reset_in_hold: got %h want 0", all_out);
    end
    tick;
    rst = 1'b0;
    tick;
    issue(32'h608, 32'h0000_02B7, 1'b0);
    n_cmp++;
    if ({id_valid, id_pc, id_inst, id_imm_sel, id_fetch_err, id_illegal} !==
        {1'b1, 32'h608, 32'h0000_02B7, SEL_U, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL post_reset_fetch: got v=%b pc=%h inst=%h sel=%0d err=%b ill=%b want v=1 pc=608 inst=000002b7 sel=3 err=0 ill=0",
                        id_valid, id_pc, id_inst, id_imm_sel, id_fetch_err, id_illegal);
    end
    id_ready = 1'b1;
    tick;
    id_ready = 1'b0;
  endtask

  task automatic test_random;
    localparam int M_IDLE = 0, M_REQ = 1, M_WAIT = 2, M_HOLD = 3;
    logic [6:0]  ops[12];
    int          m_ph;
    logic        m_drain, m_err, m_ill, rsp_pend;
    logic [2:0]  m_sel;
    logic [31:0] m_pc, m_inst;
    int unsigned cyc, m_deadline, rsp_at;
    logic        e_rdy, e_req, e_idv;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73, 7'h7F, 7'h0B};
    idle_inputs();
    rst = 1'b1;
    tick;
    rst = 1'b0;
    m_ph = M_IDLE; m_drain = 1'b0; m_err = 1'b0; m_ill = 1'b0; m_sel = SEL_I;
    m_pc = '0; m_inst = '0; rsp_pend = 1'b0; cyc = 0; m_deadline = 0; rsp_at = 0;
    for (int n = 0; n < 3000; n++) begin
      pc_valid       = ($urandom_range(0, 9) < 7);
      pc_in          = $urandom() & 32'hFFFF_FFFC;
      imem_req_ready = ($urandom_range(0, 9) < 6);
      id_ready       = ($urandom_range(0, 1) == 1);
      flush          = ($urandom_range(0, 19) == 0);
      imem_rsp_valid = rsp_pend && (cyc == rsp_at);
      imem_rsp_data  = {$urandom() >> 7, ops[$urandom_range(0, 11)]};
      imem_rsp_err   = imem_rsp_valid && ($urandom_range(0, 9) == 0);
      #1;
      e_rdy = (m_ph == M_IDLE) && !m_drain;
      e_req = (m_ph == M_REQ) && !flush;
      e_idv = (m_ph == M_HOLD);
      n_cmp++;
      if ({pc_ready, imem_req_valid, id_valid} !== {e_rdy, e_req, e_idv}) begin
        n_bad++; $display("FAIL rand_handshake@%0d: got rdy/req/idv %b%b%b want %b%b%b",
                          cyc, pc_ready, imem_req_valid, id_valid, e_rdy, e_req, e_idv);
      end
      if (e_req) begin
        n_cmp++;
        if (imem_req_addr !== m_pc) begin
          n_bad++; $display("FAIL rand_req_addr@%0d: got %h want %h", cyc, imem_req_addr, m_pc);
        end
      end
      if (e_idv) begin
        n_cmp++;
        if ({id_pc, id_inst, id_imm_sel, id_illegal, id_fetch_err} !==
            {m_pc, m_inst, m_sel, m_ill, m_err}) begin
          n_bad++; $display("FAIL rand_issue@%0d: got pc=%h inst=%h sel=%0d ill=%b err=%b want pc=%h inst=%h sel=%0d ill=%b err=%b",
                            cyc, id_pc, id_inst, id_imm_sel, id_illegal, id_fetch_err,
                            m_pc, m_inst, m_sel, m_ill, m_err);
        end
      end
      if (imem_rsp_valid) rsp_pend = 1'b0;
      if (e_req && imem_req_ready && $urandom_range(0, 4) != 0) begin
        rsp_pend = 1'b1;
        rsp_at   = cyc + 1 + $urandom_range(0, TMO - 1);
      end
      case (m_ph)
        M_IDLE: begin
          if (m_drain) begin
            if (imem_rsp_valid || cyc == m_deadline) m_drain = 1'b0;
          end else if (pc_valid) begin
            m_pc = pc_in; m_ph = M_REQ;
          end
        end
        M_REQ: begin
          if (flush) m_ph = M_IDLE;
          else if (imem_req_ready) begin m_ph = M_WAIT; m_deadline = cyc + TMO; end
        end
        M_WAIT: begin
          if (flush) begin
            m_drain = !imem_rsp_valid && (cyc != m_deadline);
            m_ph    = M_IDLE;
          end else if (imem_rsp_valid && !imem_rsp_err) begin
            {m_ill, m_sel} = ref_decode(imem_rsp_data);
            m_inst = imem_rsp_data; m_err = 1'b0; m_ph = M_HOLD;
          end else if (imem_rsp_valid || cyc == m_deadline) begin
            m_inst = NOP; m_sel = SEL_I; m_ill = 1'b0; m_err = 1'b1; m_ph = M_HOLD;
          end
        end
        default: if (flush || id_ready) m_ph = M_IDLE;
      endcase
      cyc++;
      tick;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_auipc();
    test_hold_stall();
    test_decode();
    test_flush();
    test_drain_timeout();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
